// File: rtl/cordic_engine_if.sv
// Operand/result handshake bundle for cordic_engine.
// The engine connects through the slave view; whoever feeds operands and
// drains results uses the master view.
interface cordic_engine_if #(
  parameter int WIDTH = 16
);
  // Operand side
  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic signed [WIDTH-1:0] x_i;
  logic signed [WIDTH-1:0] y_i;
  logic signed [WIDTH-1:0] z_i;

  // Result side
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] x_o;
  logic signed [WIDTH-1:0] y_o;
  logic signed [WIDTH-1:0] z_o;

  modport master (
    output in_valid, mode, x_i, y_i, z_i, out_ready,
    input  in_ready, out_valid, x_o, y_o, z_o
  );

  modport slave (
    input  in_valid, mode, x_i, y_i, z_i, out_ready,
    output in_ready, out_valid, x_o, y_o, z_o
  );
endinterface

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine, rotation (z -> 0) and vectoring (y -> 0) modes.
// One operand at a time: IDLE -> PRE (quadrant fold) -> ITER micro-rotations
// -> SCALE (gain compensation, rounding, saturation) -> DONE (hold result).
// Datapath registers carry two guard bits so the CORDIC gain never wraps.
// Constants (atan table, pi/2, 1/gain) are kept in Q30 and rounded to FRAC
// fractional bits at elaboration; FRAC must lie in 1..29 and ITER in 1..24.
module cordic_engine #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 7,
  parameter int ITER  = 12
) (
  input  logic          clk,
  input  logic          reset,
  cordic_engine_if.slave bus
);

  localparam int IW = WIDTH + 2;         // internal x/y/z width
  localparam int PW = IW + FRAC + 2;     // width of the gain product
  localparam int CW = 5;                 // iteration index width (up to 32 steps)

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // atan(2^-i) scaled by 2^30, i = 0..31 (entries past 24 are never reached
  // but keep the table a power-of-two deep so the 5-bit index is exact).
  localparam longint ATAN_Q30 [32] = '{
    64'sd843314857, 64'sd497837830, 64'sd263043837, 64'sd133525159,
    64'sd67021687,  64'sd33543516,  64'sd16775851,  64'sd8388437,
    64'sd4194283,   64'sd2097149,   64'sd1048576,   64'sd524288,
    64'sd262144,    64'sd131072,    64'sd65536,     64'sd32768,
    64'sd16384,     64'sd8192,      64'sd4096,      64'sd2048,
    64'sd1024,      64'sd512,       64'sd256,       64'sd128,
    64'sd64,        64'sd32,        64'sd16,        64'sd8,
    64'sd4,         64'sd2,         64'sd1,         64'sd0
  };

  // Round a Q30 constant to the engine's Q format (round half up).
  function automatic longint round_q30(input longint v);
    return (v + (longint'(1) <<< (29 - FRAC))) >>> (30 - FRAC);
  endfunction

  localparam logic signed [IW-1:0] HALF_PI   = IW'(round_q30(64'sd1686629713));
  localparam logic signed [PW-1:0] K_MUL     = PW'(round_q30(64'sd652032874));
  localparam logic signed [PW-1:0] ROUND_ADD = PW'(longint'(1) <<< (FRAC - 1));
  localparam logic signed [PW-1:0] SAT_MAX   = PW'((longint'(1) <<< (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN   = PW'(-(longint'(1) <<< (WIDTH - 1)));

  // Elaboration-time arctangent table in the engine's Q format
  logic signed [IW-1:0] atan_tab [32];

  for (genvar gi = 0; gi < 32; gi++) begin : g_atan
    localparam longint A_RND = round_q30(ATAN_Q30[gi]);
    assign atan_tab[gi] = IW'(A_RND);
  end

  // Sign-extend a port-width value into the guarded internal width.
  function automatic logic signed [IW-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Multiply by 1/gain, round half up, drop FRAC bits, clamp to port range.
  function automatic logic signed [WIDTH-1:0] sat_scale(input logic signed [IW-1:0] v);
    logic signed [PW-1:0] p;
    p = (PW'(v) * K_MUL + ROUND_ADD) >>> FRAC;
    if (p > SAT_MAX) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else if (p < SAT_MIN) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end
    return WIDTH'(p);
  endfunction

  logic [2:0]              state_reg, state_next;
  logic [CW-1:0]           iter_reg,  iter_next;
  logic                    mode_reg,  mode_next;
  logic signed [IW-1:0]    x_reg, x_next;
  logic signed [IW-1:0]    y_reg, y_next;
  logic signed [IW-1:0]    z_reg, z_next;
  logic signed [WIDTH-1:0] xo_reg, xo_next;
  logic signed [WIDTH-1:0] yo_reg, yo_next;
  logic signed [WIDTH-1:0] zo_reg, zo_next;

  logic signed [IW-1:0]    pre_x, pre_y, pre_z;
  logic signed [IW-1:0]    x_sh, y_sh;
  logic signed [IW-1:0]    x_step, y_step, z_step;
  logic                    rot_pos;

  // Quadrant fold so the micro-rotations only need to cover +/- pi/2
  always_comb begin
    pre_x = x_reg;
    pre_y = y_reg;
    pre_z = z_reg;
    if (!mode_reg) begin
      if (z_reg > HALF_PI) begin
        pre_x = -y_reg;
        pre_y = x_reg;
        pre_z = z_reg - HALF_PI;
      end else if (z_reg < -HALF_PI) begin
        pre_x = y_reg;
        pre_y = -x_reg;
        pre_z = z_reg + HALF_PI;
      end
    end else if (x_reg[IW-1]) begin
      if (!y_reg[IW-1]) begin
        pre_x = y_reg;
        pre_y = -x_reg;
        pre_z = z_reg + HALF_PI;
      end else begin
        pre_x = -y_reg;
        pre_y = x_reg;
        pre_z = z_reg - HALF_PI;
      end
    end
  end

  // One shift-and-add micro-rotation using the current iteration index
  always_comb begin
    x_sh    = x_reg >>> iter_reg;
    y_sh    = y_reg >>> iter_reg;
    rot_pos = mode_reg ? y_reg[IW-1] : ~z_reg[IW-1];
    if (rot_pos) begin
      x_step = x_reg - y_sh;
      y_step = y_reg + x_sh;
      z_step = z_reg - atan_tab[iter_reg];
    end else begin
      x_step = x_reg + y_sh;
      y_step = y_reg - x_sh;
      z_step = z_reg + atan_tab[iter_reg];
    end
  end

  // Sequencer and register next-state selection
  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    mode_next  = mode_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    xo_next    = xo_reg;
    yo_next    = yo_reg;
    zo_next    = zo_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
          mode_next  = bus.mode;
          x_next     = sext(bus.x_i);
          y_next     = sext(bus.y_i);
          z_next     = sext(bus.z_i);
          state_next = S_PRE;
        end
      end
      S_PRE: begin
        x_next     = pre_x;
        y_next     = pre_y;
        z_next     = pre_z;
        iter_next  = '0;
        state_next = S_ITER;
      end
      S_ITER: begin
        x_next    = x_step;
        y_next    = y_step;
        z_next    = z_step;
        iter_next = iter_reg + CW'(1);
        if (iter_reg == CW'(ITER - 1)) begin
          state_next = S_SCALE;
        end
      end
      S_SCALE: begin
        xo_next    = sat_scale(x_reg);
        yo_next    = sat_scale(y_reg);
        zo_next    = WIDTH'(z_reg);
        state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      iter_reg  <= '0;
      mode_reg  <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      xo_reg    <= '0;
      yo_reg    <= '0;
      zo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
      mode_reg  <= mode_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      z_reg     <= z_next;
      xo_reg    <= xo_next;
      yo_reg    <= yo_next;
      zo_reg    <= zo_next;
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.x_o       = xo_reg;
  assign bus.y_o       = yo_reg;
  assign bus.z_o       = zo_reg;

endmodule

// File: tb/tb_cordic_engine.sv
// Self-checking bench for cordic_engine at default parameters.
// Reference: the CORDIC rules evaluated with unbounded integer arithmetic,
// with the arctangent table and constants derived from real-valued math.
module tb_cordic_engine;

  localparam int WIDTH = 16;
  localparam int FRAC  = 7;
  localparam int ITER  = 12;
  localparam int LAT   = ITER + 2;

  logic clk = 1'b0;
  logic reset;

  cordic_engine_if #(.WIDTH(WIDTH)) bus ();

  cordic_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int atan_t [ITER];
  int k_gain;
  int half_pi;
  int last_x, last_y, last_z;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = (obs > exp) ? obs - exp : exp - obs;
    n_tests++;
    assert (diff <= tol) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d(+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Integer evaluation of quadrant fold, micro-rotations and gain scaling.
  function automatic void ref_model(input int m, input int xi, input int yi, input int zi,
                                    output int xo, output int yo, output int zo);
    longint x, y, z, xn, yn, r;
    int d;
    x = xi; y = yi; z = zi;
    if (m == 0) begin
      if (z > half_pi)       begin xn = -y; yn = x;  x = xn; y = yn; z = z - half_pi; end
      else if (z < -half_pi) begin xn = y;  yn = -x; x = xn; y = yn; z = z + half_pi; end
    end else if (x < 0) begin
      if (y >= 0) begin xn = y;  yn = -x; x = xn; y = yn; z = z + half_pi; end
      else        begin xn = -y; yn = x;  x = xn; y = yn; z = z - half_pi; end
    end
    for (int i = 0; i < ITER; i++) begin
      if (m == 0) d = (z >= 0) ? 1 : -1;
      else        d = (y < 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      yn = y + d * (x >>> i);
      z  = z - d * atan_t[i];
      x  = xn;
      y  = yn;
    end
    r  = (x * k_gain + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    xo = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
    r  = (y * k_gain + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    yo = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
    zo = int'(shortint'(z));
  endfunction

  task automatic send(input int m, input int x, input int y, input int z);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_send", int'(bus.in_ready), 1);
    bus.mode     = m[0];
    bus.x_i      = 16'(x);
    bus.y_i      = 16'(y);
    bus.z_i      = 16'(z);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_clear"}, int'(bus.out_valid), 0);
    check({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
  endtask

  task automatic do_op(input string tag, input int m, input int x, input int y, input int z,
                       input bit rdy_early);
    int ex, ey, ez, lat;
    ref_model(m, x, y, z, ex, ey, ez);
    bus.out_ready = rdy_early;
    send(m, x, y, z);
    collect(lat);
    last_x = int'(bus.x_o);
    last_y = int'(bus.y_o);
    last_z = int'(bus.z_o);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_x"}, last_x, ex);
    check({tag, "_y"}, last_y, ey);
    check({tag, "_z"}, last_z, ez);
    $display("[TB] %s mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) ref=(%0d,%0d,%0d) lat=%0d",
             tag, m, x, y, z, last_x, last_y, last_z, ex, ey, ez, lat);
    if (rdy_early) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, "_out_valid_clear"}, int'(bus.out_valid), 0);
      check({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
    end else begin
      consume(tag);
    end
    check({tag, "_x_held_idle"}, int'(bus.x_o), ex);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, lat, ax, ay, az, bx, by, bz, bad_data, bad_ready, bad_valid;
    int m, x, y, z;

    for (int i = 0; i < ITER; i++) begin
      atan_t[i] = $rtoi($floor($atan($pow(2.0, -1.0 * i)) * 128.0 + 0.5));
    end
    k_gain  = $rtoi($floor(0.6072529350 * 128.0 + 0.5));
    half_pi = $rtoi($floor(3.14159265358979 / 2.0 * 128.0 + 0.5));

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.x_i       = '0;
    bus.y_i       = '0;
    bus.z_i       = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_x_o", int'(bus.x_o), 0);
    check("rst_y_o", int'(bus.y_o), 0);
    check("rst_z_o", int'(bus.z_o), 0);
    @(posedge clk); #3;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("idle_no_out_valid", seen, 0);

    // Directed rotation cases
    do_op("rot_halfpi", 0, 128, 0, 201, 1'b0);
    check_near("rot_halfpi_x_near", last_x, 0, 6);
    check_near("rot_halfpi_y_near", last_y, 128, 6);
    check_near("rot_halfpi_z_near", last_z, 0, 2);
    do_op("rot_pi", 0, 128, 0, 402, 1'b1);
    check_near("rot_pi_x_near", last_x, -128, 6);
    check_near("rot_pi_y_near", last_y, 0, 6);
    do_op("rot_negpi", 0, 100, -50, -402, 1'b0);
    do_op("rot_edge_neg", 0, 90, 40, -201, 1'b0);
    do_op("rot_edge_pos", 0, -70, 110, 202, 1'b1);

    // Directed vectoring cases
    do_op("vec_diag", 1, 128, 128, 0, 1'b0);
    check_near("vec_diag_x_near", last_x, 181, 6);
    check_near("vec_diag_y_near", last_y, 0, 3);
    check_near("vec_diag_z_near", last_z, 101, 3);
    do_op("vec_negx", 1, -128, 0, 0, 1'b0);
    check_near("vec_negx_x_near", last_x, 128, 6);
    check_near("vec_negx_z_near", last_z, 402, 3);
    do_op("vec_negxy", 1, -128, -1, 0, 1'b1);
    check_near("vec_negxy_z_near", last_z, -402, 3);

    // Saturation
    do_op("sat", 0, 32767, 32767, 101, 1'b0);
    check("sat_y_clamped", last_y, 32767);

    // Backpressure: result held, a second operand waits for IDLE
    ref_model(0, 300, -200, 150, ax, ay, az);
    ref_model(1, -500, 700, 20, bx, by, bz);
    bus.out_ready = 1'b0;
    send(0, 300, -200, 150);
    collect(lat);
    check("bp_a_latency", lat, LAT);
    bus.mode = 1'b1; bus.x_i = -16'sd500; bus.y_i = 16'sd700; bus.z_i = 16'sd20;
    bus.in_valid = 1'b1;
    bad_data = 0; bad_ready = 0; bad_valid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (int'(bus.x_o) != ax || int'(bus.y_o) != ay || int'(bus.z_o) != az) bad_data++;
      if (bus.in_ready !== 1'b0) bad_ready++;
      if (bus.out_valid !== 1'b1) bad_valid++;
    end
    check("bp_data_stable", bad_data, 0);
    check("bp_in_ready_low", bad_ready, 0);
    check("bp_out_valid_held", bad_valid, 0);
    $display("[TB] bp_a out=(%0d,%0d,%0d) ref=(%0d,%0d,%0d)",
             int'(bus.x_o), int'(bus.y_o), int'(bus.z_o), ax, ay, az);
    consume("bp_a");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_b_accepted", int'(bus.in_ready), 0);
    collect(lat);
    check("bp_b_latency", lat, LAT);
    check("bp_b_x", int'(bus.x_o), bx);
    check("bp_b_y", int'(bus.y_o), by);
    check("bp_b_z", int'(bus.z_o), bz);
    $display("[TB] bp_b out=(%0d,%0d,%0d) ref=(%0d,%0d,%0d) lat=%0d",
             int'(bus.x_o), int'(bus.y_o), int'(bus.z_o), bx, by, bz, lat);
    consume("bp_b");

    // Reset in the middle of the iterations
    send(0, 1000, 500, 300);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_x_o", int'(bus.x_o), 0);
    check("mid_rst_y_o", int'(bus.y_o), 0);
    check("mid_rst_z_o", int'(bus.z_o), 0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    check("mid_rst_no_result", seen, 0);
    do_op("after_rst", 0, -640, 320, -100, 1'b0);

    // Randomized operands
    for (int t = 0; t < 20; t++) begin
      m = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 32000)) - 16000;
      y = int'($urandom_range(0, 32000)) - 16000;
      if (m == 0) z = int'($urandom_range(0, 804)) - 402;
      else        z = int'($urandom_range(0, 200)) - 100;
      do_op($sformatf("rnd%0d", t), m, x, y, z, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
